// File: rtl/window_ctrl_if.sv
// Request/response bundle between the control unit and window_ctrl.
// master = control unit side, slave = window controller side.
interface window_ctrl_if #(
    parameter int unsigned NWINDOWS = 8,
    parameter int unsigned CWP_W    = 5
);
    logic                save_req;
    logic                restore_req;
    logic                trap_entry;
    logic                cwp_we;
    logic [CWP_W-1:0]    cwp_in;
    logic                wim_we;
    logic [NWINDOWS-1:0] wim_in;
    logic [CWP_W-1:0]    cwp;
    logic [NWINDOWS-1:0] wim;
    logic                op_ack;
    logic                trap_ovf;
    logic                trap_unf;
    logic                busy;

    modport master (
        output save_req, restore_req, trap_entry, cwp_we, cwp_in, wim_we, wim_in,
        input  cwp, wim, op_ack, trap_ovf, trap_unf, busy
    );

    modport slave (
        input  save_req, restore_req, trap_entry, cwp_we, cwp_in, wim_we, wim_in,
        output cwp, wim, op_ack, trap_ovf, trap_unf, busy
    );
endinterface

// File: rtl/window_ctrl.sv
// SPARC register-window controller: owns CWP/WIM, serves SAVE/RESTORE and trap entry.
// Define WINDOW_CTRL_AUTO_SPILL_EN to replace overflow/underflow traps by hardware spill/fill.
module window_ctrl #(
    parameter int unsigned NWINDOWS = 8,
    parameter int unsigned CWP_W    = 5,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              Clk,
    input  logic              RESET_n,
    window_ctrl_if.slave      bus
`ifdef WINDOW_CTRL_AUTO_SPILL_EN
    ,
    input  logic [ADDR_W-1:0] spill_base,
    output logic [CWP_W-1:0]  rf_win,
    output logic [3:0]        rf_reg,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_wr_en,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`endif
);

    typedef enum logic [2:0] {StIdle, StResp, StSpillRd, StSpillWr, StFillRd, StFillWr} state_e;

    localparam logic [CWP_W-1:0]    LastWin = CWP_W'(NWINDOWS - 1);
    localparam logic [NWINDOWS-1:0] WimRst  = NWINDOWS'(2);

    if (NWINDOWS < 2 || NWINDOWS > 32 || (1 << CWP_W) < NWINDOWS || ADDR_W < 8 || DATA_W == 0)
    begin : g_cfg_err
        $error("window_ctrl: illegal parameter set");
    end

    function automatic logic [CWP_W-1:0] f_dec(input logic [CWP_W-1:0] x);
        return (x == '0) ? LastWin : x - 1'b1;
    endfunction

    function automatic logic [CWP_W-1:0] f_inc(input logic [CWP_W-1:0] x);
        return (x == LastWin) ? '0 : x + 1'b1;
    endfunction

    function automatic logic [NWINDOWS-1:0] f_oh(input logic [CWP_W-1:0] x);
        return NWINDOWS'(1) << x;
    endfunction

    state_e              r_state, w_state_nxt;
    logic [CWP_W-1:0]    r_cwp, w_cwp_nxt, w_new;
    logic [NWINDOWS-1:0] r_wim, w_wim_nxt;
    logic                r_ack, w_ack_nxt, r_ovf, w_ovf_nxt, r_unf, w_unf_nxt;
    logic                w_wr_evt, w_can_req, w_take_save, w_take_rest, w_hit;

`ifdef WINDOW_CTRL_AUTO_SPILL_EN
    logic [CWP_W-1:0]  r_new, w_new_nxt, r_aux, w_aux_nxt, r_rf_win, w_rf_win_nxt;
    logic [3:0]        r_idx, w_idx_nxt;
    logic              r_mem_req, w_mem_req_nxt, r_mem_we, w_mem_we_nxt;
    logic              r_rf_wr_en, w_rf_wr_en_nxt, w_last;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt, w_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt, r_rf_wr_data, w_rf_wr_data_nxt;
`endif

    always_comb begin
        w_wr_evt    = bus.cwp_we | bus.wim_we;
        // A request still held during the op_ack cycle counts as a fresh one.
        w_can_req   = ((r_state == StIdle) && !w_wr_evt && !bus.trap_entry) ||
                      ((r_state == StResp) && r_ack);
        w_take_save = w_can_req & bus.save_req;
        w_take_rest = w_can_req & ~bus.save_req & bus.restore_req;
        w_new       = w_take_save ? f_dec(r_cwp) : f_inc(r_cwp);
        w_hit       = |(r_wim & f_oh(w_new));

        w_state_nxt = r_state;
        w_cwp_nxt   = r_cwp;
        w_wim_nxt   = r_wim;
        w_ack_nxt   = 1'b0;
        w_ovf_nxt   = 1'b0;
        w_unf_nxt   = 1'b0;
`ifdef WINDOW_CTRL_AUTO_SPILL_EN
        w_new_nxt        = r_new;
        w_aux_nxt        = r_aux;
        w_rf_win_nxt     = r_rf_win;
        w_idx_nxt        = r_idx;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_rf_wr_en_nxt   = 1'b0;
        w_rf_wr_data_nxt = r_rf_wr_data;
        w_last           = 1'b0;
        w_addr           = '0;
`endif

        case (r_state)
            StIdle: begin
                if (w_wr_evt) begin
                    if (bus.cwp_we && bus.cwp_in <= LastWin) w_cwp_nxt = bus.cwp_in;
                    if (bus.wim_we) w_wim_nxt = bus.wim_in;
                end else if (bus.trap_entry) begin
                    w_cwp_nxt = f_dec(r_cwp);
                end
            end
            StResp: w_state_nxt = StIdle;
`ifdef WINDOW_CTRL_AUTO_SPILL_EN
            StSpillRd: w_state_nxt = StSpillWr;
            StSpillWr: begin
                // First cycle here has the register-file read data; latch it and request.
                if (!r_mem_req) begin
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_wdata_nxt = rf_rd_data;
                end else if (mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    if (r_idx == 4'hF) begin
                        w_last = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + 4'd1;
                        w_state_nxt = StSpillRd;
                    end
                end
            end
            StFillRd: begin
                if (mem_ack) begin
                    w_mem_req_nxt    = 1'b0;
                    w_rf_wr_en_nxt   = 1'b1;
                    w_rf_wr_data_nxt = mem_rdata;
                    w_state_nxt      = StFillWr;
                end
            end
            StFillWr: begin
                if (r_idx == 4'hF) begin
                    w_last = 1'b1;
                end else begin
                    w_idx_nxt     = r_idx + 4'd1;
                    w_mem_req_nxt = 1'b1;
                    w_mem_we_nxt  = 1'b0;
                    w_state_nxt   = StFillRd;
                end
            end
`endif
            default: w_state_nxt = StIdle;
        endcase

`ifdef WINDOW_CTRL_AUTO_SPILL_EN
        if (w_last) begin
            w_wim_nxt   = (r_wim & ~f_oh(r_new)) | f_oh(r_aux);
            w_cwp_nxt   = r_new;
            w_ack_nxt   = 1'b1;
            w_state_nxt = StResp;
        end
`endif

        if (w_take_save || w_take_rest) begin
            w_state_nxt = StResp;
            if (!w_hit) begin
                w_cwp_nxt = w_new;
                w_ack_nxt = 1'b1;
            end else begin
`ifdef WINDOW_CTRL_AUTO_SPILL_EN
                w_new_nxt = w_new;
                w_idx_nxt = 4'd0;
                if (w_take_save) begin
                    w_aux_nxt    = f_dec(w_new);
                    w_rf_win_nxt = f_dec(w_new);
                    w_state_nxt  = StSpillRd;
                end else begin
                    w_aux_nxt     = f_inc(w_new);
                    w_rf_win_nxt  = w_new;
                    w_mem_req_nxt = 1'b1;
                    w_mem_we_nxt  = 1'b0;
                    w_state_nxt   = StFillRd;
                end
`else
                w_ovf_nxt = w_take_save;
                w_unf_nxt = w_take_rest;
`endif
            end
        end

`ifdef WINDOW_CTRL_AUTO_SPILL_EN
        w_addr = spill_base + (ADDR_W'(w_rf_win_nxt) << 6) + (ADDR_W'(w_idx_nxt) << 2);
        if (w_mem_req_nxt && !r_mem_req) w_mem_addr_nxt = w_addr;
`endif
    end

    always_ff @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state <= StIdle;
            r_cwp   <= '0;
            r_wim   <= WimRst;
            r_ack   <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
`ifdef WINDOW_CTRL_AUTO_SPILL_EN
            r_new        <= '0;
            r_aux        <= '0;
            r_rf_win     <= '0;
            r_idx        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rf_wr_en   <= 1'b0;
            r_rf_wr_data <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cwp   <= w_cwp_nxt;
            r_wim   <= w_wim_nxt;
            r_ack   <= w_ack_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
`ifdef WINDOW_CTRL_AUTO_SPILL_EN
            r_new        <= w_new_nxt;
            r_aux        <= w_aux_nxt;
            r_rf_win     <= w_rf_win_nxt;
            r_idx        <= w_idx_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_rf_wr_en   <= w_rf_wr_en_nxt;
            r_rf_wr_data <= w_rf_wr_data_nxt;
`endif
        end
    end

    assign bus.cwp      = r_cwp;
    assign bus.wim      = r_wim;
    assign bus.op_ack   = r_ack;
    assign bus.trap_ovf = r_ovf;
    assign bus.trap_unf = r_unf;
    assign bus.busy     = (r_state != StIdle);

`ifdef WINDOW_CTRL_AUTO_SPILL_EN
    assign rf_win     = r_rf_win;
    assign rf_reg     = r_idx;
    assign rf_wr_en   = r_rf_wr_en;
    assign rf_wr_data = r_rf_wr_data;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
`endif

endmodule

// File: tb/tb_window_ctrl.sv
// Bench for window_ctrl: an 8-window and a 5-window instance checked every cycle against
// a modular-arithmetic model, plus directed literal checks.
module tb_window_ctrl;

    logic Clk     = 1'b0;
    logic RESET_n = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    bit   m8_en   = 1'b1;

    always #5 Clk = ~Clk;

    window_ctrl_if #(.NWINDOWS(8), .CWP_W(5)) if8 ();
    window_ctrl_if #(.NWINDOWS(5), .CWP_W(3)) if5 ();

`ifdef WINDOW_CTRL_AUTO_SPILL_EN
    logic [31:0] spill_base = 32'h180;
    logic [4:0]  rf_win8;
    logic [3:0]  rf_reg8;
    logic [31:0] rf_rd8, rf_wd8, mem_addr8, mem_wd8;
    logic        rf_we8, mem_req8, mem_we8;
    logic        mem_ack8 = 1'b0;
    logic [2:0]  rf_win5;
    logic [3:0]  rf_reg5;
    logic [31:0] rf_wd5, mem_addr5, mem_wd5;
    logic        rf_we5, mem_req5, mem_we5;
    logic [31:0] wr_q[$];

    assign rf_rd8 = 32'hA000 + 32'(rf_reg8);

    always @(posedge Clk) begin
        mem_ack8 <= mem_req8 && !mem_ack8;
        if (mem_req8 && mem_ack8 && mem_we8) wr_q.push_back(mem_addr8);
    end
`endif

    window_ctrl #(.NWINDOWS(8), .CWP_W(5), .ADDR_W(32), .DATA_W(32)) u8 (
        .Clk(Clk), .RESET_n(RESET_n), .bus(if8)
`ifdef WINDOW_CTRL_AUTO_SPILL_EN
        , .spill_base(spill_base), .rf_win(rf_win8), .rf_reg(rf_reg8), .rf_rd_data(rf_rd8),
        .rf_wr_en(rf_we8), .rf_wr_data(rf_wd8), .mem_req(mem_req8), .mem_we(mem_we8),
        .mem_addr(mem_addr8), .mem_wdata(mem_wd8), .mem_rdata(32'h0), .mem_ack(mem_ack8)
`endif
    );

    window_ctrl #(.NWINDOWS(5), .CWP_W(3), .ADDR_W(32), .DATA_W(32)) u5 (
        .Clk(Clk), .RESET_n(RESET_n), .bus(if5)
`ifdef WINDOW_CTRL_AUTO_SPILL_EN
        , .spill_base(32'h0), .rf_win(rf_win5), .rf_reg(rf_reg5), .rf_rd_data(32'h0),
        .rf_wr_en(rf_we5), .rf_wr_data(rf_wd5), .mem_req(mem_req5), .mem_we(mem_we5),
        .mem_addr(mem_addr5), .mem_wdata(mem_wd5), .mem_rdata(32'h0), .mem_ack(1'b0)
`endif
    );

    // Architectural model: window arithmetic done modulo n, one response cycle per request.
    typedef struct {
        int          cwp;
        logic [31:0] wim;
        bit          busy, ack, ovf, unf;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.cwp = 0; r.wim = 32'h2; r.busy = 0; r.ack = 0; r.ovf = 0; r.unf = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, int n, bit sv, bit rs, bit te, bit cwe, int cin,
                                      bit wwe, logic [31:0] win);
        mdl_t r = s;
        int   nw;
        bit   free = !s.busy;
        r.busy = 0; r.ack = 0; r.ovf = 0; r.unf = 0;
        if (free && (cwe || wwe)) begin
            if (cwe && cin < n) r.cwp = cin;
            if (wwe) r.wim = win & ((32'd1 << n) - 1);
        end else if (free && te) begin
            r.cwp = (s.cwp + n - 1) % n;
        end else if ((free || s.ack) && (sv || rs)) begin
            nw = sv ? (s.cwp + n - 1) % n : (s.cwp + 1) % n;
            r.busy = 1;
            if (s.wim[nw]) begin
                r.ovf = sv;
                r.unf = !sv;
            end else begin
                r.cwp = nw;
                r.ack = 1;
            end
        end
        return r;
    endfunction

    mdl_t m8, m5;

    always @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            m8 <= mdl_reset();
            m5 <= mdl_reset();
        end else begin
            m8 <= mdl_step(m8, 8, if8.save_req, if8.restore_req, if8.trap_entry, if8.cwp_we,
                           int'(if8.cwp_in), if8.wim_we, 32'(if8.wim_in));
            m5 <= mdl_step(m5, 5, if5.save_req, if5.restore_req, if5.trap_entry, if5.cwp_we,
                           int'(if5.cwp_in), if5.wim_we, 32'(if5.wim_in));
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_out(input string tag, input logic [31:0] cwp, input logic [31:0] wim,
                           input logic ack, input logic ovf, input logic unf, input logic busy,
                           input mdl_t e);
        chk({tag, "_cwp"}, cwp, 32'(e.cwp));
        chk({tag, "_wim"}, wim, e.wim);
        chk({tag, "_op_ack"}, 32'(ack), 32'(e.ack));
        chk({tag, "_trap_ovf"}, 32'(ovf), 32'(e.ovf));
        chk({tag, "_trap_unf"}, 32'(unf), 32'(e.unf));
        chk({tag, "_busy"}, 32'(busy), 32'(e.busy));
    endtask

    always @(negedge Clk) begin
        if (m8_en)
            cmp_out("m8", 32'(if8.cwp), 32'(if8.wim), if8.op_ack, if8.trap_ovf, if8.trap_unf,
                    if8.busy, RESET_n ? m8 : mdl_reset());
        cmp_out("m5", 32'(if5.cwp), 32'(if5.wim), if5.op_ack, if5.trap_ovf, if5.trap_unf,
                if5.busy, RESET_n ? m5 : mdl_reset());
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drv8(input bit sv, input bit rs, input bit te, input bit cwe,
                        input logic [4:0] cin, input bit wwe, input logic [7:0] win);
        if8.save_req = sv; if8.restore_req = rs; if8.trap_entry = te;
        if8.cwp_we = cwe; if8.cwp_in = cin; if8.wim_we = wwe; if8.wim_in = win;
    endtask

    task automatic step8(input bit sv, input bit rs, input bit te, input bit cwe,
                         input logic [4:0] cin, input bit wwe, input logic [7:0] win);
        drv8(sv, rs, te, cwe, cin, wwe, win);
        tick();
        drv8(0, 0, 0, 0, 5'd0, 0, 8'h0);
    endtask

    task automatic step5(input bit sv, input bit rs, input bit wwe, input logic [4:0] win);
        if5.save_req = sv; if5.restore_req = rs; if5.wim_we = wwe; if5.wim_in = win;
        tick();
        if5.save_req = 0; if5.restore_req = 0; if5.wim_we = 0; if5.wim_in = '0;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        n_err++;
        summary();
        $finish;
    end

    initial begin
        int exp_cwp[6];
        exp_cwp = '{7, 6, 5, 4, 3, 2};
        drv8(0, 0, 0, 0, 5'd0, 0, 8'h0);
        if5.save_req = 0; if5.restore_req = 0; if5.trap_entry = 0;
        if5.cwp_we = 0; if5.cwp_in = '0; if5.wim_we = 0; if5.wim_in = '0;
`ifdef WINDOW_CTRL_AUTO_SPILL_EN
        m8_en = 1'b0;
`endif
        idle(3);
        RESET_n = 1'b1;
        chk("rst_cwp", 32'(if8.cwp), 32'd0);
        chk("rst_wim", 32'(if8.wim), 32'h02);
        chk("rst_busy", 32'(if8.busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            step8(1, 0, 0, 0, 5'd0, 0, 8'h0);
            chk("save_ack", 32'(if8.op_ack), 32'd1);
            chk("save_cwp", 32'(if8.cwp), 32'(exp_cwp[i]));
            idle(1);
            chk("save_ack_drop", 32'(if8.op_ack), 32'd0);
        end

`ifndef WINDOW_CTRL_AUTO_SPILL_EN
        step8(1, 0, 0, 0, 5'd0, 0, 8'h0);
        chk("ovf_pulse", 32'(if8.trap_ovf), 32'd1);
        chk("ovf_cwp", 32'(if8.cwp), 32'd2);
        idle(1);
`endif
        step8(0, 0, 0, 1, 5'd0, 0, 8'h0);
        chk("cwp_write0", 32'(if8.cwp), 32'd0);
`ifndef WINDOW_CTRL_AUTO_SPILL_EN
        step8(0, 1, 0, 0, 5'd0, 0, 8'h0);
        chk("unf_pulse", 32'(if8.trap_unf), 32'd1);
        chk("unf_cwp", 32'(if8.cwp), 32'd0);
        idle(1);
`endif

        // Held save: second acceptance happens in the op_ack cycle.
        drv8(1, 0, 0, 0, 5'd0, 0, 8'h0);
        tick();
        chk("b2b_cwp1", 32'(if8.cwp), 32'd7);
        tick();
        chk("b2b_cwp2", 32'(if8.cwp), 32'd6);
        chk("b2b_ack2", 32'(if8.op_ack), 32'd1);
        drv8(0, 0, 0, 0, 5'd0, 0, 8'h0);
        idle(1);

        step8(0, 0, 0, 1, 5'd3, 1, 8'h00);
        chk("both_we_cwp", 32'(if8.cwp), 32'd3);
        chk("both_we_wim", 32'(if8.wim), 32'h00);
        step8(1, 1, 0, 0, 5'd0, 0, 8'h0);
        chk("save_wins_cwp", 32'(if8.cwp), 32'd2);
        idle(1);

`ifndef WINDOW_CTRL_AUTO_SPILL_EN
        drv8(1, 0, 0, 0, 5'd0, 1, 8'h02);
        tick();
        chk("wim_first_ack", 32'(if8.op_ack), 32'd0);
        chk("wim_first_wim", 32'(if8.wim), 32'h02);
        drv8(1, 0, 0, 0, 5'd0, 0, 8'h0);
        tick();
        chk("pend_save_ovf", 32'(if8.trap_ovf), 32'd1);
        chk("pend_save_cwp", 32'(if8.cwp), 32'd2);
        drv8(0, 0, 0, 0, 5'd0, 0, 8'h0);
        idle(1);
`endif

        step8(0, 0, 0, 1, 5'd0, 1, 8'h80);
        step8(0, 0, 1, 0, 5'd0, 0, 8'h0);
        chk("te_cwp", 32'(if8.cwp), 32'd7);
        chk("te_no_ovf", 32'(if8.trap_ovf), 32'd0);
        step8(0, 0, 0, 1, 5'd9, 0, 8'h0);
        chk("cwp_in9_ignored", 32'(if8.cwp), 32'd7);
        step8(1, 0, 0, 0, 5'd0, 0, 8'h0);
        chk("save_7to6", 32'(if8.cwp), 32'd6);
        step8(0, 0, 1, 0, 5'd0, 0, 8'h0);
        chk("te_busy_ignored", 32'(if8.cwp), 32'd6);

        step5(0, 0, 1, 5'h00);
        chk("n5_wim0", 32'(if5.wim), 32'h0);
        step5(1, 0, 0, 5'h00);
        chk("n5_save_wrap", 32'(if5.cwp), 32'd4);
        idle(1);
        step5(0, 1, 0, 5'h00);
        chk("n5_restore_wrap", 32'(if5.cwp), 32'd0);
        chk("n5_restore_ack", 32'(if5.op_ack), 32'd1);
        idle(2);

`ifdef WINDOW_CTRL_AUTO_SPILL_EN
        RESET_n = 1'b0;
        idle(2);
        RESET_n = 1'b1;
        step8(0, 0, 0, 1, 5'd2, 0, 8'h0);
        wr_q.delete();
        step8(1, 0, 0, 0, 5'd0, 0, 8'h0);
        for (int i = 0; i < 300 && !if8.op_ack; i++) tick();
        chk("spill_done", 32'(if8.op_ack), 32'd1);
        chk("spill_cwp", 32'(if8.cwp), 32'd1);
        chk("spill_wim", 32'(if8.wim), 32'h01);
        chk("spill_nwr", 32'(wr_q.size()), 32'd16);
        for (int i = 0; i < wr_q.size(); i++) chk("spill_addr", wr_q[i], 32'h180 + 32'(i * 4));
        idle(1);
        step8(1, 0, 0, 0, 5'd0, 0, 8'h0);
        idle(6);
        #2 RESET_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req8), 32'd0);
        chk("rst_mid_cwp", 32'(if8.cwp), 32'd0);
        tick();
        RESET_n = 1'b1;
        idle(2);
`endif

        summary();
        $finish;
    end

endmodule
